// File: rtl/uart_tx_fifo_if.sv
// Core-to-transmitter byte handshake for uart_tx_fifo.
// Valid/ready: a byte moves on a rising clk edge where txvalid && txready are both high;
// txdata must be stable while txvalid is high, and txready never depends on txvalid.
interface uart_tx_fifo_if;
    logic [7:0] txdata;
    logic       txvalid;
    logic       txready;

    modport master (output txdata, output txvalid, input txready);
    modport slave  (input txdata, input txvalid, output txready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed through a small byte FIFO.
// Back-to-back frames are contiguous: the next byte is loaded in the last stop-bit cycle.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_fifo_if.slave                 tx,
    output logic                          txd,
    output logic                          txbusy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    dbg_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            baud_done;

    // txready looks only at count, so a pop in the same cycle never frees a slot early.
    assign tx.txready = (count < DEPTH_C);
    assign push       = tx.txvalid && tx.txready;
    assign baud_done  = (baud == BAUD_LAST);
    assign pop        = (count != '0) && ((state == IDLE) || (state == STOP && baud_done));
    assign txbusy     = (state != IDLE) || (count != '0);
    assign fifo_count = count;
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx.txdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd     <= 1'b1;
                    baud    <= '0;
                    bit_idx <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        txd     <= shift[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            // txd is registered, so present the next bit straight from shift[1].
                            shift   <= {1'b0, shift[7:1]};
                            txd     <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            txd   <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model, line decoder and directed/random steps.
module tb_uart_tx_fifo;
    localparam int C = 4;
    localparam int D = 4;
    localparam int FRAME = 10 * C;
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txd;
    logic       txbusy;
    logic [2:0] fifo_count;
    logic [1:0] dbg_state;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx         (bus.slave),
        .txd        (txd),
        .txbusy     (txbusy),
        .fifo_count (fifo_count),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queued bytes plus the position inside the current frame.
    logic [7:0] mdl_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] cur_byte = 8'h00;
    int         ft = -1;

    // Line decoder state.
    logic       dec_busy = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic line_bit(input int t, input logic [7:0] b);
        int i;
        if (t < 0) return 1'b1;
        i = t / C;
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mdl_q.delete();
            exp_q.delete();
            ft = -1;
        end else begin
            int  sz;
            logic pushed;
            logic popped;
            sz     = mdl_q.size();
            pushed = bus.txvalid && (sz < D);
            popped = (sz > 0) && (ft < 0 || ft == FRAME - 1);
            if (ft >= 0 && ft < FRAME - 1) ft++;
            else if (popped) begin
                cur_byte = mdl_q.pop_front();
                ft = 0;
            end else ft = -1;
            if (pushed) begin
                mdl_q.push_back(bus.txdata);
                exp_q.push_back(bus.txdata);
            end
        end
    end

    initial forever begin
        @(posedge rst);
        dec_busy = 1'b0;
    end

    // Per-cycle output check and serial decode, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("txd",        txd,        line_bit(ft, cur_byte));
        check("txready",    bus.txready, (mdl_q.size() < D));
        check("txbusy",     txbusy,     (ft >= 0) || (mdl_q.size() > 0));
        check("fifo_count", fifo_count, mdl_q.size());
        if (!rst) begin
            if (!dec_busy && txd == 1'b0) begin
                dec_busy = 1'b1;
                dec_cnt  = 0;
            end
            if (dec_busy) begin
                if (dec_cnt % C == C / 2) begin
                    int idx;
                    idx = dec_cnt / C;
                    if (idx == 0) check("dec_start", txd, 1'b0);
                    else if (idx <= 8) dec_byte[idx-1] = txd;
                    else begin
                        check("dec_stop", txd, 1'b1);
                        check("dec_have_expected", exp_q.size() != 0, 1'b1);
                        if (exp_q.size() != 0) check("dec_byte", dec_byte, exp_q.pop_front());
                    end
                end
                dec_cnt++;
                if (dec_cnt == FRAME) dec_busy = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        bus.txdata  = b;
        bus.txvalid = 1'b1;
        while (!bus.txready && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        check("send_timeout", guard < LIMIT, 1'b1);
        @(negedge clk);
        bus.txvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (txbusy && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        check("idle_timeout", guard < LIMIT, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cnt;
        bus.txvalid = 1'b0;
        bus.txdata  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_txready", bus.txready, 1'b1);
        check("rst_txbusy", txbusy, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte timing.
        send(8'hA5);
        check("a5_count_after_push", fifo_count, 3'd1);
        check("a5_txd_before_pop", txd, 1'b1);
        @(negedge clk);
        check("a5_start_low", txd, 1'b0);
        check("a5_count_after_pop", fifo_count, 3'd0);
        repeat (39) @(negedge clk);
        check("a5_busy_last_stop", txbusy, 1'b1);
        @(negedge clk);
        check("a5_busy_fall", txbusy, 1'b0);
        wait_idle();

        // Back-to-back frames are contiguous.
        send(8'h01);
        send(8'h02);
        send(8'h03);
        cnt = 0;
        while (txbusy && cnt < LIMIT) begin
            cnt++;
            @(negedge clk);
        end
        check("b2b_busy_span", cnt, 119);
        wait_idle();

        // Backpressure and full-with-pop.
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
        check("full_count", fifo_count, 3'd4);
        check("full_txready", bus.txready, 1'b0);
        bus.txdata  = 8'h15;
        bus.txvalid = 1'b1;
        cnt = 0;
        while (!bus.txready && cnt < LIMIT) begin
            @(negedge clk);
            cnt++;
        end
        check("full_wait_bounded", cnt < LIMIT, 1'b1);
        check("full_pop_no_push", fifo_count, 3'd3);
        @(negedge clk);
        bus.txvalid = 1'b0;
        check("full_push_next_edge", fifo_count, 3'd4);
        wait_idle();

        // Reset in the middle of DATA bit 3 of 0xFF.
        send(8'hFF);
        repeat (18) @(negedge clk);
        check("mid_bit3_high", txd, 1'b1);
        bus.txdata  = 8'($urandom);
        bus.txvalid = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("midrst_txd", txd, 1'b1);
        check("midrst_txready", bus.txready, 1'b1);
        check("midrst_txbusy", txbusy, 1'b0);
        check("midrst_count", fifo_count, 3'd0);
        @(negedge clk);
        bus.txvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", txbusy, 1'b0);
        send(8'h00);
        wait_idle();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.txvalid = 1'($urandom_range(0, 1));
            bus.txdata  = 8'($urandom);
            @(negedge clk);
        end
        bus.txvalid = 1'b0;
        wait_idle();

        check("all_bytes_seen", exp_q.size(), 0);
        check("decoder_idle", dec_busy, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
